// File: rtl/ddr_pkg.sv
// Shared types and defaults for the controller read-data capture path.
// The read word type is sized from the default DQ_W/BURST_LEN constants below;
// change them here together with any parameter override of ctrl_rd_capture.
package ddr_pkg;

  localparam int DQ_W_DEF      = 8;
  localparam int BURST_LEN_DEF = 8;
  localparam int WORD_W        = DQ_W_DEF * BURST_LEN_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    PUSH = 2'd3
  } rd_cap_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              err;
  } rd_word_t;

  // A valid DQS pair is always complementary; equal levels mean a strobe fault.
  function automatic logic strobe_bad(input logic t, input logic c);
    return t == c;
  endfunction

endpackage

// File: rtl/ctrl_rd_fifo.sv
// Small synchronous FIFO of captured read words.
// Head entry is held in a register so the output stays stable (and holds its
// last value) when the FIFO runs empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and
// flagged on drop.
module ctrl_rd_fifo
  import ddr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     srst,
  input  logic     push,
  input  rd_word_t wdata,
  input  logic     pop,
  output rd_word_t head,
  output logic     empty,
  output logic     full,
  output logic     drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  rd_word_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  rd_word_t         head_reg;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = head_reg;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array, written without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointer/count registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Registered head: next stored entry on a pop, the incoming word when it
  // becomes the only entry, otherwise hold.
  always_ff @(posedge clk) begin
    if (srst) begin
      head_reg <= '0;
    end else if (do_pop && count_reg > CNT_W'(1)) begin
      head_reg <= mem[rd_ptr_next];
    end else if (do_push && (empty || (do_pop && count_reg == CNT_W'(1)))) begin
      head_reg <= wdata;
    end
  end

endmodule

// File: rtl/ctrl_rd_capture.sv
// Controller-side read-data capture: arms on rd_start, waits RD_LAT cycles,
// captures BURST_LEN beats LSB-first with a DQS pair check, and queues the
// packed word for the host.
// Optional feature macro: CTRL_RD_DBI_EN (undo data-bus inversion per beat).
module ctrl_rd_capture
  import ddr_pkg::*;
#(
  parameter int DQ_W       = DQ_W_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int RD_LAT     = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      CK_t,
  input  logic                      reset,
  input  logic                      rd_start,
  input  logic [DQ_W-1:0]           dq,
  input  logic                      dqs_t,
  input  logic                      dqs_c,
  input  logic                      dbi_n,
  output logic [DQ_W*BURST_LEN-1:0] rd_data,
  output logic                      rd_data_err,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      busy,
  output logic                      overlap_err,
  output logic                      ovf_err
);

  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  rd_cap_state_e             state_reg, state_next;
  logic [LAT_W-1:0]          lat_cnt_reg, lat_cnt_next;
  logic [BEAT_W-1:0]         beat_cnt_reg, beat_cnt_next;
  logic [DQ_W*BURST_LEN-1:0] word_reg, word_next;
  logic                      err_reg, err_next;
  logic                      overlap_err_reg;
  logic                      ovf_err_reg;

  logic                      lat_done;
  logic                      capture_en;
  logic [BEAT_W-1:0]         beat_idx;
  logic                      last_beat;
  logic [DQ_W-1:0]           beat_data;
  logic                      push;

  rd_word_t                  fifo_wdata;
  rd_word_t                  fifo_head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_drop;

  // Beat 0 is sampled on the same edge that leaves WAIT, so the first beat
  // lands exactly RD_LAT edges after rd_start; CAPT then takes beats 1..N-1.
  assign lat_done   = (state_reg == WAIT) && (lat_cnt_reg == LAT_W'(RD_LAT - 1));
  assign capture_en = lat_done || (state_reg == CAPT);
  assign beat_idx   = (state_reg == CAPT) ? beat_cnt_reg : '0;
  assign last_beat  = (beat_idx == BEAT_W'(BURST_LEN - 1));

`ifdef CTRL_RD_DBI_EN
  assign beat_data = dbi_n ? dq : ~dq;
`else
  logic unused_dbi_n;
  assign unused_dbi_n = dbi_n;
  assign beat_data    = dq;
`endif

  // One lane per beat: each byte slot loads only on its own capture beat.
  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_lane
      assign word_next[gi*DQ_W +: DQ_W] =
        (capture_en && beat_idx == BEAT_W'(gi)) ? beat_data : word_reg[gi*DQ_W +: DQ_W];
    end
  endgenerate

  // Sequencing: IDLE -> WAIT -> CAPT -> PUSH -> IDLE, plus the strobe error flag.
  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    push          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rd_start) begin
          state_next   = WAIT;
          lat_cnt_next = '0;
          err_next     = 1'b0;
        end
      end
      WAIT: begin
        if (lat_done) begin
          beat_cnt_next = BEAT_W'(1);
          state_next    = last_beat ? PUSH : CAPT;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end
      CAPT: begin
        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
        if (last_beat) state_next = PUSH;
      end
      PUSH: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (capture_en && strobe_bad(dqs_t, dqs_c)) err_next = 1'b1;
  end

  // State, counters, packed word and the one-cycle error pulses.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= '0;
      beat_cnt_reg    <= '0;
      word_reg        <= '0;
      err_reg         <= 1'b0;
      overlap_err_reg <= 1'b0;
      ovf_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lat_cnt_reg     <= lat_cnt_next;
      beat_cnt_reg    <= beat_cnt_next;
      word_reg        <= word_next;
      err_reg         <= err_next;
      overlap_err_reg <= rd_start && (state_reg != IDLE);
      ovf_err_reg     <= fifo_drop;
    end
  end

  assign fifo_wdata.data = word_reg;
  assign fifo_wdata.err  = err_reg;

  ctrl_rd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CK_t),
    .srst  (reset),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (rd_ready),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  assign rd_data     = fifo_head.data;
  assign rd_data_err = fifo_head.err;
  assign rd_valid    = !fifo_empty;
  assign busy        = (state_reg != IDLE);
  assign overlap_err = overlap_err_reg;
  assign ovf_err     = ovf_err_reg;

endmodule

// File: tb/tb_ctrl_rd_capture.sv
// Bench for ctrl_rd_capture: directed scenarios plus randomized reads, checked
// every cycle against a transaction-level model (timestamps + word queue).
module tb_ctrl_rd_capture;

  localparam int DQ_W       = 8;
  localparam int BURST_LEN  = 8;
  localparam int RD_LAT     = 11;
  localparam int FIFO_DEPTH = 4;
  localparam int WW         = DQ_W * BURST_LEN;

  logic          CK_t = 1'b0;
  logic          reset;
  logic          rd_start;
  logic [DQ_W-1:0] dq;
  logic          dqs_t, dqs_c, dbi_n;
  logic [WW-1:0] rd_data;
  logic          rd_data_err, rd_valid, rd_ready, busy, overlap_err, ovf_err;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;

  ctrl_rd_capture #(
    .DQ_W(DQ_W), .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CK_t(CK_t), .reset(reset), .rd_start(rd_start), .dq(dq), .dqs_t(dqs_t),
    .dqs_c(dqs_c), .dbi_n(dbi_n), .rd_data(rd_data), .rd_data_err(rd_data_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
    .overlap_err(overlap_err), .ovf_err(ovf_err)
  );

  always #5 CK_t = ~CK_t;

  task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WW:0]   m_q[$];
  logic [WW:0]   m_head;
  logic [WW-1:0] m_word;
  bit            m_err, m_active, m_ovl, m_ovf, model_ok = 0;
  int            cyc = 0, m_start = 0;

  always @(posedge CK_t) begin
    bit pop;
    int rel, k;
    logic [DQ_W-1:0] b;
    cyc++;
    if (reset) begin
      m_q.delete(); m_head = '0; m_active = 0; m_ovl = 0; m_ovf = 0; model_ok = 1;
    end else if (model_ok) begin
      pop   = (m_q.size() > 0) && rd_ready;
      m_ovl = 0;
      m_ovf = 0;
      if (m_active) begin
        if (rd_start) m_ovl = 1;
        rel = cyc - m_start;
        if (rel >= RD_LAT && rel < RD_LAT + BURST_LEN) begin
          k = rel - RD_LAT;
          b = dq;
`ifdef CTRL_RD_DBI_EN
          if (!dbi_n) b = ~dq;
`endif
          m_word[k*DQ_W +: DQ_W] = b;
          if (dqs_t == dqs_c) m_err = 1;
        end else if (rel == RD_LAT + BURST_LEN) begin
          if (pop) begin void'(m_q.pop_front()); pop = 0; end
          if (m_q.size() < FIFO_DEPTH) m_q.push_back({m_word, m_err});
          else m_ovf = 1;
          m_active = 0;
        end
      end else if (rd_start) begin
        m_active = 1; m_start = cyc; m_err = 0; m_word = '0;
      end
      if (pop) void'(m_q.pop_front());
      if (m_q.size() > 0) m_head = m_q[0];
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge CK_t) begin
    if (model_ok) begin
      check("rd_valid", WW'(rd_valid), WW'(m_q.size() > 0));
      check("busy", WW'(busy), WW'(m_active));
      check("overlap_err", WW'(overlap_err), WW'(m_ovl));
      check("ovf_err", WW'(ovf_err), WW'(m_ovf));
      check("rd_data", rd_data, m_head[WW:1]);
      check("rd_data_err", WW'(rd_data_err), WW'(m_head[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CK_t);
    #1;
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
  endtask

  // Issues one read and drives its burst; returns just after the PUSH edge
  // (or right after a reset injected at beat rst_beat).
  task automatic read_burst(input logic [WW-1:0] w, input int bad_beat,
                            input logic [BURST_LEN-1:0] dbi_bits, input int ovl_beat,
                            input int rst_beat, input bit ready_at_push);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    dqs_t = 1'b1; dqs_c = 1'b1;            // not checked outside capture
    repeat (RD_LAT - 1) begin dq = 8'($urandom); step(); end
    for (int k = 0; k < BURST_LEN; k++) begin
      dq       = w[k*DQ_W +: DQ_W];
      dbi_n    = dbi_bits[k];
      dqs_t    = k[0];
      dqs_c    = (k == bad_beat) ? k[0] : ~k[0];
      rd_start = (k == ovl_beat);
      if (k == rst_beat) reset = 1'b1;
      step();
      rd_start = 1'b0;
      if (k == rst_beat) begin
        reset = 1'b0;
        check("reset_busy", WW'(busy), '0);
        check("reset_valid", WW'(rd_valid), '0);
        return;
      end
      if (k == ovl_beat) check("overlap_pulse", WW'(overlap_err), WW'(1));
    end
    check("busy_before_push", WW'(busy), WW'(1));
    dq = 8'($urandom); dqs_t = 1'b0; dqs_c = 1'b0; dbi_n = 1'b1;
    if (ready_at_push) rd_ready = 1'b1;
    step();
    if (ready_at_push) rd_ready = 1'b0;
    $display("read word=%h bad_beat=%0d dbi=%h -> valid=%0b head=%h err=%0b ovf=%0b",
             w, bad_beat, dbi_bits, rd_valid, rd_data, rd_data_err, ovf_err);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (FIFO_DEPTH + 1) step();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] exp_b0;
    reset = 1'b1; rd_start = 1'b0; dq = '0; dqs_t = 1'b0; dqs_c = 1'b1;
    dbi_n = 1'b1; rd_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", WW'(rd_valid), '0);
    check("rst_busy", WW'(busy), '0);
    check("rst_data", rd_data, '0);
    check("rst_err", WW'(rd_data_err), '0);
    check("rst_ovl", WW'(overlap_err), '0);
    check("rst_ovf", WW'(ovf_err), '0);
    reset = 1'b0;
    step();

    // 1: single read
    read_burst(64'h0807060504030201, -1, '1, -1, -1, 0);
    check("t1_valid", WW'(rd_valid), WW'(1));
    check("t1_data", rd_data, 64'h0807060504030201);
    check("t1_err", WW'(rd_data_err), '0);
    drain();

    // 2: strobe fault on beat 3
    read_burst(64'h1122334455667788, 3, '1, -1, -1, 0);
    check("t2_err", WW'(rd_data_err), WW'(1));
    check("t2_data", rd_data, 64'h1122334455667788);
    drain();

    // 3: overflow on the fifth read, then drain in order
    for (int i = 1; i <= 5; i++) begin
      w = {8{8'(i)}};
      read_burst(w, -1, '1, -1, -1, 0);
      check("t3_ovf", WW'(ovf_err), WW'(i == 5));
    end
    for (int i = 1; i <= 4; i++) begin
      w = {8{8'(i)}};
      check("t3_order", rd_data, w);
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    check("t3_empty", WW'(rd_valid), '0);

    // 4: full FIFO with a pop on the PUSH edge
    for (int i = 1; i <= 4; i++) begin
      w = {8{8'(8'h10 + 8'(i))}};
      read_burst(w, -1, '1, -1, -1, 0);
    end
    read_burst({8{8'hA5}}, -1, '1, -1, -1, 1);
    check("t4_no_ovf", WW'(ovf_err), '0);
    check("t4_head", rd_data, {8{8'h12}});
    repeat (3) begin rd_ready = 1'b1; step(); end
    rd_ready = 1'b0;
    check("t4_tail", rd_data, {8{8'hA5}});
    drain();

    // 5: overlap during capture, then reset at beat 4
    read_burst(64'hDEADBEEFCAFEF00D, -1, '1, 2, -1, 0);
    check("t5_data", rd_data, 64'hDEADBEEFCAFEF00D);
    drain();
    read_burst(64'h0123456789ABCDEF, -1, '1, -1, 4, 0);
    repeat (BURST_LEN + 4) step();
    check("t5_no_push", WW'(rd_valid), '0);

    // 6: data-bus inversion on beat 0
    read_burst(64'h00000000000000FE, -1, 8'hFE, -1, -1, 0);
`ifdef CTRL_RD_DBI_EN
    exp_b0 = 64'h01;
`else
    exp_b0 = 64'hFE;
`endif
    check("t6_byte0", WW'(rd_data[7:0]), exp_b0);
    drain();

    // randomized reads with random host readiness
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      w = {$urandom, $urandom};
      read_burst(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                 8'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1,
                 -1, 0);
      repeat ($urandom_range(0, 3)) begin dq = 8'($urandom); step(); end
    end
    rand_ready = 0;
    rd_ready = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
